// File: rtl/steelhorse_rxq_pkg.sv
// rtl/steelhorse_rxq_pkg.sv - shared write-FSM state type and pointer/length width helpers for the rx queue
package steelhorse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } wr_state_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packet length must hold DEPTH itself, hence one extra bit.
    function automatic int len_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/steelhorse_rxq_if.sv
// rtl/steelhorse_rxq_if.sv - MAC write / packet read bus of the rx queue; drop_cnt only with STEELHORSE_RXQ_DROPCNT_EN
interface steelhorse_rxq_if
    import steelhorse_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) ();
    localparam int AW = ptr_w(DEPTH);
    localparam int LW = len_w(DEPTH);

    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_eop;
    logic              wr_abort;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              pkt_valid;
    logic [LW-1:0]     pkt_len;
    logic              pkt_pop;
    logic              nwpckt_irq;
    logic              full;
`ifdef STEELHORSE_RXQ_DROPCNT_EN
    logic [15:0]       drop_cnt;
`endif

    modport master (
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        input  drop_cnt,
`endif
        output wr_data, wr_valid, wr_eop, wr_abort, rd_addr, pkt_pop,
        input  rd_data, pkt_valid, pkt_len, nwpckt_irq, full
    );

    modport slave (
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        output drop_cnt,
`endif
        input  wr_data, wr_valid, wr_eop, wr_abort, rd_addr, pkt_pop,
        output rd_data, pkt_valid, pkt_len, nwpckt_irq, full
    );

endinterface

// File: rtl/steelhorse_rxq_ram.sv
// rtl/steelhorse_rxq_ram.sv - simple dual-port SLOTS*DEPTH x DATA_W packet RAM with registered read
module steelhorse_rxq_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/steelhorse_rxq.sv
// rtl/steelhorse_rxq.sv - slotted receive packet queue; optional drop counter under STEELHORSE_RXQ_DROPCNT_EN
module steelhorse_rxq
    import steelhorse_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SLOTS  = 4,
    parameter int DEPTH  = 512
) (
    input  logic             clk,
    input  logic             rst,
    steelhorse_rxq_if.slave  q
);
    localparam int PW = ptr_w(SLOTS);
    localparam int AW = ptr_w(DEPTH);
    localparam int LW = len_w(DEPTH);
    localparam int OW = PW + 1;

    wr_state_t     state, state_n;
    logic [PW-1:0] head, tail;
    logic [OW-1:0] occ;
    logic [LW-1:0] wr_off, wr_off_n;
    logic [LW-1:0] len_q [SLOTS];
    logic [AW-1:0] mem_off;
    logic          mem_we, commit, drop_evt, pop_ok, has_free, irq_q;

    // A slot freed by a pop only becomes claimable once occ has updated.
    assign has_free = (occ != OW'(SLOTS));
    assign pop_ok   = q.pkt_pop && (occ != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        wr_off_n = wr_off;
        mem_off  = wr_off[AW-1:0];
        mem_we   = 1'b0;
        commit   = 1'b0;
        drop_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q.wr_abort && q.wr_valid) begin
                    if (has_free) begin
                        mem_we   = 1'b1;
                        mem_off  = '0;
                        wr_off_n = LW'(1);
                        if (q.wr_eop) begin
                            commit = 1'b1;
                        end else begin
                            state_n = ST_FILL;
                        end
                    end else if (q.wr_eop) begin
                        drop_evt = 1'b1;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
            end
            ST_FILL: begin
                if (q.wr_abort) begin
                    state_n = ST_IDLE;
                end else if (q.wr_valid) begin
                    if (wr_off == LW'(DEPTH)) begin
                        // Slot already holds DEPTH words: this packet cannot fit.
                        if (q.wr_eop) begin
                            drop_evt = 1'b1;
                            state_n  = ST_IDLE;
                        end else begin
                            state_n  = ST_DROP;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_off_n = wr_off + LW'(1);
                        if (q.wr_eop) begin
                            commit  = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (q.wr_abort) begin
                    state_n = ST_IDLE;
                end else if (q.wr_valid && q.wr_eop) begin
                    drop_evt = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            wr_off <= '0;
            irq_q  <= 1'b0;
        end else begin
            wr_off <= wr_off_n;
            irq_q  <= commit;
            if (commit) begin
                tail <= tail + PW'(1);
            end
            if (pop_ok) begin
                head <= head + PW'(1);
            end
            occ <= occ + OW'(commit) - OW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            len_q[tail] <= wr_off_n;
        end
    end

    steelhorse_rxq_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (PW + AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr ({tail, mem_off}),
        .wdata (q.wr_data),
        .raddr ({head, q.rd_addr}),
        .rdata (q.rd_data)
    );

    assign q.pkt_valid  = (occ != '0);
    assign q.pkt_len    = q.pkt_valid ? len_q[head] : '0;
    assign q.nwpckt_irq = irq_q;
    assign q.full       = (occ == OW'(SLOTS));

`ifdef STEELHORSE_RXQ_DROPCNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_evt && drop_cnt_q != 16'hffff) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign q.drop_cnt = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop_evt;
`endif

endmodule

// File: tb/tb_steelhorse_rxq.sv
// tb/tb_steelhorse_rxq.sv - directed self-checking bench for steelhorse_rxq (DROP_CNT checks with STEELHORSE_RXQ_DROPCNT_EN)
module tb_steelhorse_rxq;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
`ifdef STEELHORSE_RXQ_DROPCNT_EN
    int   exp_drop = 0;
`endif

    always #5 clk = ~clk;

    steelhorse_rxq_if #(.DATA_W(32), .DEPTH(512)) bus ();

    steelhorse_rxq #(.DATA_W(32), .SLOTS(4), .DEPTH(512)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input int abort_at, input bit pop_eop);
        for (int i = 0; i < len; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 32'(i);
            bus.wr_eop   = (i == len - 1);
            bus.wr_abort = (i == abort_at);
            bus.pkt_pop  = pop_eop && (i == len - 1);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        bus.wr_eop   = 1'b0;
        bus.wr_abort = 1'b0;
        bus.pkt_pop  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
        bus.rd_addr = 9'(addr);
        @(negedge clk);
        chk(tag, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic pop;
        bus.pkt_pop = 1'b1;
        @(negedge clk);
        bus.pkt_pop = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.wr_data  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_eop   = 1'b0;
        bus.wr_abort = 1'b0;
        bus.rd_addr  = '0;
        bus.pkt_pop  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pkt_valid", 64'(bus.pkt_valid), 0);
        chk("rst_pkt_len", 64'(bus.pkt_len), 0);
        chk("rst_irq", 64'(bus.nwpckt_irq), 0);
        chk("rst_full", 64'(bus.full), 0);
        chk("rst_rd_data", 64'(bus.rd_data), 0);
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        chk("rst_drop_cnt", 64'(bus.drop_cnt), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 8-word packet
        send_pkt(8, 32'h1234_5678, -1, 1'b0);
        chk("p8_irq", 64'(bus.nwpckt_irq), 1);
        chk("p8_valid", 64'(bus.pkt_valid), 1);
        chk("p8_len", 64'(bus.pkt_len), 8);
        @(negedge clk);
        chk("p8_irq_pulse", 64'(bus.nwpckt_irq), 0);
        for (int i = 0; i < 8; i++) rd_chk("p8_rd", i, 32'h1234_5678 + 32'(i));
        pop();
        chk("p8_popped", 64'(bus.pkt_valid), 0);

        // abort on word 5 together with EOP, then a good 3-word packet
        send_pkt(5, 32'h0000_0A00, 4, 1'b0);
        chk("abort_irq", 64'(bus.nwpckt_irq), 0);
        chk("abort_valid", 64'(bus.pkt_valid), 0);
        send_pkt(3, 32'h0000_0B00, -1, 1'b0);
        chk("p3_irq", 64'(bus.nwpckt_irq), 1);
        chk("p3_len", 64'(bus.pkt_len), 3);
        rd_chk("p3_rd0", 0, 32'h0000_0B00);
        rd_chk("p3_rd2", 2, 32'h0000_0B02);
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        chk("abort_drop_cnt", 64'(bus.drop_cnt), 0);
`endif
        pop();

        // fill all slots, then overflow
        for (int k = 1; k <= 4; k++) begin
            send_pkt(k, 32'(k) << 8, -1, 1'b0);
            chk("fill_full", 64'(bus.full), (k == 4) ? 1 : 0);
        end
        send_pkt(2, 32'h0000_0F00, -1, 1'b0);
        chk("ovf_irq", 64'(bus.nwpckt_irq), 0);
        send_pkt(1, 32'h0000_0E00, -1, 1'b0);
        chk("ovf1_irq", 64'(bus.nwpckt_irq), 0);
        chk("ovf_full", 64'(bus.full), 1);
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        exp_drop = 2;
        chk("ovf_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
`endif
        for (int k = 1; k <= 4; k++) begin
            chk("fifo_len", 64'(bus.pkt_len), 64'(k));
            rd_chk("fifo_rd0", 0, 32'(k) << 8);
            pop();
            chk("fifo_full_after_pop", 64'(bus.full), 0);
        end
        chk("fifo_empty", 64'(bus.pkt_valid), 0);

        // commit and pop in the same cycle
        send_pkt(2, 32'h0000_2000, -1, 1'b0);
        send_pkt(3, 32'h0000_3000, -1, 1'b1);
        chk("cp_irq", 64'(bus.nwpckt_irq), 1);
        chk("cp_valid", 64'(bus.pkt_valid), 1);
        chk("cp_len", 64'(bus.pkt_len), 3);
        rd_chk("cp_rd1", 1, 32'h0000_3001);
        pop();
        chk("cp_empty", 64'(bus.pkt_valid), 0);

        // exactly DEPTH words fits, DEPTH+1 is dropped
        send_pkt(512, 32'h0010_0000, -1, 1'b0);
        chk("max_irq", 64'(bus.nwpckt_irq), 1);
        chk("max_len", 64'(bus.pkt_len), 512);
        rd_chk("max_rd511", 511, 32'h0010_01FF);
        pop();
        send_pkt(513, 32'h0020_0000, -1, 1'b0);
        chk("ovl_irq", 64'(bus.nwpckt_irq), 0);
        chk("ovl_valid", 64'(bus.pkt_valid), 0);
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        exp_drop = 3;
        chk("ovl_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
`endif
        send_pkt(2, 32'h0000_4000, -1, 1'b0);
        chk("post_ovl_irq", 64'(bus.nwpckt_irq), 1);
        chk("post_ovl_len", 64'(bus.pkt_len), 2);
        pop();

        // reset in the middle of a packet with two queued
        send_pkt(2, 32'h0000_5000, -1, 1'b0);
        send_pkt(3, 32'h0000_6000, -1, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h0000_7000;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", 64'(bus.pkt_valid), 0);
        chk("mrst_full", 64'(bus.full), 0);
        chk("mrst_len", 64'(bus.pkt_len), 0);
        send_pkt(2, 32'h0000_8000, -1, 1'b0);
        chk("mrst_irq", 64'(bus.nwpckt_irq), 1);
        chk("mrst_new_len", 64'(bus.pkt_len), 2);
        rd_chk("mrst_rd1", 1, 32'h0000_8001);
`ifdef STEELHORSE_RXQ_DROPCNT_EN
        chk("mrst_drop_cnt", 64'(bus.drop_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/steelhorse_rxq.md
STEELHORSE_RXQ -- requirements
Module: steelhorse_rxq

Interface
REQ-001 Parameter DATA_W, default 32, width of each stored word.
REQ-002 Parameter SLOTS, default 4, number of packet slots (power of two, >=2).
REQ-003 Parameter DEPTH, default 512, words per slot (power of two).
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 WR_DATA  in  DATA_W  word from receiver MAC.
REQ-007 WR_VALID  in  1  WR_DATA is valid this cycle.
REQ-008 WR_EOP  in  1  qualified by WR_VALID; current word is the last of the packet.
REQ-009 WR_ABORT  in  1  discard packet in progress (bad CRC/runt); independent of WR_VALID.
REQ-010 RD_ADDR  in  log2(DEPTH)  word index within head slot.
REQ-011 RD_DATA  out  DATA_W  head-slot word at RD_ADDR.
REQ-012 PKT_VALID  out  1  a committed packet is at the head.
REQ-013 PKT_LEN  out  log2(DEPTH)+1  head packet length in words.
REQ-014 PKT_POP  in  1  release head slot.
REQ-015 NWPCKT_IRQ  out  1  one-cycle pulse per committed packet.
REQ-016 FULL  out  1  all SLOTS committed.
REQ-017 DROP_CNT  out  16  dropped-packet counter (present only under macro, REQ-035).

Function
REQ-018 Write FSM states: IDLE, FILL, DROP.
REQ-019 IDLE + WR_VALID + free slot: word stored at offset 0 of tail slot, go FILL (or commit directly if WR_EOP).
REQ-020 IDLE + WR_VALID + no free slot: go DROP (or count drop immediately if WR_EOP).
REQ-021 FILL: each WR_VALID stores at next offset; WR_EOP commits slot: length = words written incl. EOP word, tail advances mod SLOTS, return IDLE.
REQ-022 FILL overlength: WR_VALID without WR_EOP when DEPTH words already stored -> slot discarded, go DROP.
REQ-023 DROP: ignores data; WR_VALID+WR_EOP returns to IDLE and counts one drop.
REQ-024 WR_ABORT in FILL or DROP: discard in-progress packet, no commit, no drop count, go IDLE; WR_ABORT wins over a simultaneous WR_EOP.
REQ-025 Commit: NWPCKT_IRQ high exactly the cycle after the EOP word; PKT_VALID high that same cycle if queue was empty.
REQ-026 Read side presents oldest committed slot; PKT_LEN valid whenever PKT_VALID.
REQ-027 RD_DATA registered: one-cycle latency from RD_ADDR; RD_ADDR >= PKT_LEN returns stale slot contents (undefined, no error).
REQ-028 PKT_POP with PKT_VALID: head advances mod SLOTS; next packet visible the following cycle; PKT_POP without PKT_VALID ignored.
REQ-029 Simultaneous commit and pop: both take effect, occupancy unchanged; commit into a just-freed slot allowed the cycle after pop only.
REQ-030 FULL = occupancy equals SLOTS, counted in committed slots; a slot in FILL is not counted.

Reset
REQ-031 RST: FSM IDLE, head=tail=0, occupancy 0, all queued and in-progress packets lost.
REQ-032 Reset values: PKT_VALID 0, PKT_LEN 0, NWPCKT_IRQ 0, FULL 0, RD_DATA 0, DROP_CNT 0.
REQ-033 Memory contents are not cleared by RST.
REQ-034 RST mid-packet: words after RST deassertion with no new start treated as a fresh packet start.

Configuration
REQ-035 Macro STEELHORSE_RXQ_DROPCNT_EN: defined -> DROP_CNT port exists, increments per REQ-020/022/023 drop, saturates at 16'hffff; undefined -> port and counter absent, drops silent.

Structure
REQ-036 Shared package steelhorse_pkg holds the write-FSM state enum and length/pointer width functions.
REQ-037 One sub-module steelhorse_rxq_ram: simple dual-port SLOTS*DEPTH x DATA_W RAM, registered read.

Verification
REQ-038 Write 8 words 32'h12345678.. with EOP on 8th -> IRQ pulse next cycle, PKT_VALID=1, PKT_LEN=8, RD_ADDR 0..7 returns data 1 cycle later.
REQ-039 Commit 4 packets (lengths 1,2,3,4), no pop -> FULL=1; 5th packet -> not stored, DROP_CNT=1; pops return lengths 1,2,3,4 in order.
REQ-040 513-word packet with DEPTH=512 -> no commit, no IRQ, DROP_CNT=1, FSM IDLE after EOP.
REQ-041 WR_ABORT on word 5 of a packet, then valid 3-word packet -> only the 3-word packet committed in slot 0, DROP_CNT=0.
REQ-042 Occupancy 1, PKT_POP same cycle as EOP commit -> occupancy stays 1, new packet becomes head next cycle.
REQ-043 RST asserted mid-FILL with 2 packets queued -> PKT_VALID=0, FULL=0; next packet committed in slot 0.
